// File: rtl/instr_mem_prog.sv
// Reloadable instruction memory for the fetch stage: registered read port with stall,
// NOP clear after reset, and a valid/ready program-load port with auto-incrementing address.
module instr_mem_prog #(
   parameter int                 DATA_W   = 16,
   parameter int                 ADDR_W   = 8,
   parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fetch_en,
   input  logic [ADDR_W-1:0]   addr,
   output logic [DATA_W-1:0]   rdata,
   output logic                rvalid,
   input  logic                prog_start,
   input  logic                prog_valid,
   input  logic [DATA_W-1:0]   prog_data,
   input  logic                prog_last,
   output logic                prog_ready,
   output logic                busy,
   output logic [ADDR_W:0]     prog_count
);

   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_RUN   = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   state_t              state, state_next;
   logic [ADDR_W-1:0]   clr_ptr;
   logic [ADDR_W-1:0]   wr_ptr;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic [DATA_W-1:0]   wdata;
   logic                fetch_go;
   logic                load_begin;
   logic                xfer;

   assign busy       = (state != S_RUN);
   assign prog_ready = (state == S_LOAD);

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_next = state;
      we         = 1'b0;
      waddr      = clr_ptr;
      wdata      = NOP_WORD;
      fetch_go   = 1'b0;
      load_begin = 1'b0;
      xfer       = 1'b0;
      case (state)
         S_CLEAR: begin
            we = 1'b1;
            if (clr_ptr == LAST_ADDR) state_next = S_RUN;
         end
         S_RUN: begin
            // A load request wins over a fetch issued in the same cycle.
            if (prog_start) begin
               load_begin = 1'b1;
               state_next = S_LOAD;
            end else if (fetch_en) begin
               fetch_go = 1'b1;
            end
         end
         S_LOAD: begin
            if (prog_valid && prog_ready) begin
               xfer  = 1'b1;
               we    = 1'b1;
               waddr = wr_ptr;
               wdata = prog_data;
               if (prog_last || (wr_ptr == LAST_ADDR)) state_next = S_RUN;
            end
         end
         default: state_next = S_CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_CLEAR;
         clr_ptr    <= '0;
         wr_ptr     <= '0;
         prog_count <= '0;
         rdata      <= '0;
         rvalid     <= 1'b0;
      end else begin
         state  <= state_next;
         rvalid <= fetch_go;
         if (fetch_go) rdata <= mem[addr];
         if (state == S_CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
         if (load_begin) begin
            wr_ptr     <= '0;
            prog_count <= '0;
         end else if (xfer) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (prog_count != COUNT_MAX) prog_count <= prog_count + (ADDR_W+1)'(1);
         end
      end
   end

   // NOTE: the array has no reset; the CLEAR sweep initialises it, which keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

endmodule

// File: doc/instr_mem_prog.md
# instr_mem_prog

Parametrised, reloadable instruction memory for the pipeline CPU fetch stage. Gives the fetch stage a registered read port with stall support. Accepts a new program at run time through a valid/ready load port with auto-incrementing write address. After reset it clears every word to a programmable NOP encoding, so fetch never sees undefined contents.

## Interface
Parameters:
- DATA_W, 16, instruction word width
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- NOP_WORD, 0 (16'h0000, opcode NOP), word written to every location during clear

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_en  in  1  fetch request (low = stall)
- addr  in  ADDR_W  fetch address
- rdata  out  DATA_W  registered instruction word
- rvalid  out  1  rdata updated by a fetch accepted last cycle
- prog_start  in  1  single-cycle pulse; begins a program load
- prog_valid  in  1  prog_data/prog_last valid
- prog_data  in  DATA_W  instruction word to write
- prog_last  in  1  marks final word of the load
- prog_ready  out  1  load port can accept a word
- busy  out  1  memory unavailable to fetch (CLEAR or LOAD)
- prog_count  out  ADDR_W+1  words written by the current or most recent load

## Operation
- States: CLEAR, RUN, LOAD. Single write port, single read port.
- Reset (async): state=CLEAR, clr_ptr=0, wr_ptr=0, rdata=0, rvalid=0, prog_count=0. busy=1, prog_ready=0.
- CLEAR:
  - Each cycle, mem[clr_ptr] <= NOP_WORD and clr_ptr increments.
  - After the write to DEPTH-1, go to RUN.
  - fetch_en, prog_start and prog_valid are ignored.
- RUN:
  - busy=0.
  - fetch_en=1: rdata <= mem[addr] and rvalid <= 1.
  - fetch_en=0: rdata holds its value and rvalid <= 0.
- RUN with prog_start=1:
  - prog_start takes priority over fetch_en in the same cycle; no read occurs.
  - Next state is LOAD. wr_ptr <= 0, prog_count <= 0, rvalid <= 0.
- LOAD:
  - prog_ready = (state==LOAD), decoded from state, not registered.
  - A transfer is prog_valid & prog_ready. On a transfer: mem[wr_ptr] <= prog_data, wr_ptr++, prog_count++.
  - LOAD ends on a transfer with prog_last=1, or on the transfer at wr_ptr==DEPTH-1 (overflow stop). Next state is RUN.
  - Locations not written keep their previous contents; LOAD does not clear.
  - fetch_en and prog_start are ignored. rdata holds and rvalid=0.
- prog_start outside RUN is ignored; it is not queued.
- prog_count saturates at DEPTH (it is ADDR_W+1 bits wide) and holds its value until the next prog_start in RUN.
- rst in any state, including mid-LOAD, aborts immediately and re-enters CLEAR. The partially loaded program is wiped.

## Timing
- Fetch latency: 1 cycle. fetch_en/addr sampled at edge N; rdata/rvalid are valid after edge N.
- Clear duration: exactly DEPTH cycles after rst deasserts.
  - busy falls after the edge that writes location DEPTH-1.
  - The first fetch is accepted on edge DEPTH+1 after reset release.
- Load entry: prog_start at edge N gives busy=1 and prog_ready=1 after edge N. The first word can be accepted at edge N+1.
- Load exit: the last transfer at edge M gives busy=0 and prog_ready=0 after edge M. The first fetch is accepted at edge M+1 and sees the new data.
- Throughput: one word per cycle while prog_valid stays high.
- No read-during-write hazard: fetch is blocked for the whole of CLEAR and LOAD.

## Test plan
Defaults for all scenarios: DATA_W=16, ADDR_W=8, NOP_WORD=0.
- Reset clear: fill memory via a load, assert rst, release, count cycles -> busy high for exactly 256 cycles. Fetch addr 8'd5 -> rdata=16'h0000 and rvalid=1 one cycle later.
- Basic load: prog_start, then words 16'h1110, 16'h1220, 16'h4081 with prog_last on the third -> prog_count=3 and busy=0 the cycle after. Fetch addr 2 -> rdata=16'h4081. Fetch addr 3 -> 16'h0000.
- Backpressure/gaps: prog_valid toggled 1,0,0,1,0,1 (last) with data A,x,x,B,x,C -> mem[0..2]=A,B,C and prog_count=3. prog_start pulsed mid-load -> no restart; prog_count is not reset.
- Overflow: 257 valid words with no prog_last -> prog_ready drops after the 256th transfer and prog_count=256. The 257th word is not written; mem[0] still holds word 0.
- Stall: fetch addr 7 (16'hABCD), then fetch_en=0 for 3 cycles with addr changing -> rdata stays 16'hABCD and rvalid=0 during the stall.
- Reset mid-load: after 2 of 5 words, assert rst for 1 cycle -> busy stays high through 256 clear cycles. Then fetch addr 0 and addr 1 -> 16'h0000 each; prog_count=0.
